reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
Parametrised multi-read-port register file: the next generation of the team's 8x8, 2-read/1-write register file. Width, depth and read-port count are configurable. Adds write-to-read bypass, per-port read enables with valid flags, and a hardware bulk-clear sequencer with a busy/done handshake. Sits beside the datapath ALU as the architectural register store.

Parameters:
DATA_W, 8, data bits per entry
ADDR_W, 3, address bits; DEPTH = 2**ADDR_W entries (derived localparam, not overridable)
NUM_RD, 2, number of independent read ports (1..4)
ZERO_R0, 0, when 1 entry 0 always reads 0 and writes to it are discarded

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  registered read data; port i at [i*DATA_W +: DATA_W]
rd_valid  out  NUM_RD  high for one cycle after an accepted read on that port
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ready  out  1  high when writes are accepted (= not clearing)
clr_req  in  1  request bulk clear of all entries
clr_busy  out  1  high while the clear sequencer runs
clr_done  out  1  one-cycle pulse when clear completes

Behaviour:
- Reset (rst_n low, async assert): all entries 0, rd_data 0, rd_valid 0, clr_busy 0, clr_done 0, FSM IDLE, clear index 0. Deassertion is synchronised externally.
- Read: rd_en[i]=1 at edge N -> rd_data[i] updated and rd_valid[i]=1 after edge N. rd_en[i]=0 -> rd_data[i] holds its last value, rd_valid[i]=0. Latency is exactly 1 cycle.
- Write: accepted when wr_en && wr_ready. The entry is updated at the edge. When wr_en is high and wr_ready is low, the write is silently dropped.
- Bypass (write-first): a read and an accepted write to the same address in the same cycle return wr_data. This applies to every port independently.
- Clear-sequencer writes also bypass: a read of the index being cleared returns 0.
- ZERO_R0=1: reads of address 0 return 0. Writes to address 0 are accepted (wr_ready unaffected) but have no effect. Bypass does not apply to address 0.
- FSM states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 -> CLEAR, with index 0.
  - CLEAR: writes 0 to entry[index] each cycle and increments index. At index=DEPTH-1 -> DONE. The clear takes DEPTH cycles.
  - DONE: clr_done=1 for one cycle -> IDLE.
  - clr_busy=1 in CLEAR and DONE. wr_ready = !clr_busy.
- clr_req is ignored in CLEAR and DONE and is not queued. If clr_req is held high, a new clear starts on the cycle after DONE, from IDLE.
- Reads are permitted during a clear. Each read returns the current array content: not-yet-cleared entries keep their old values.
- Index wrap: the index counter is ADDR_W bits and is never allowed to wrap within a clear.
- Reset mid-clear aborts immediately to the reset state.

Optional Feature:
REG_FILE_MP_PARITY_EN
- Defined: each entry stores one extra even-parity bit, computed from wr_data on write; cleared entries store parity 0.
- Added ports:
  - inj_par_err (in, 1): when high with an accepted write, inverts the stored parity bit.
  - rd_err (out, NUM_RD): rd_err[i] is high together with rd_valid[i] when the read entry's parity mismatches, and is 0 otherwise.
- Bypassed reads always report rd_err=0.
- Not defined: no parity storage and no extra ports; the array is DATA_W bits wide.

Test Plan:
- Reset then read all 8 addresses on both ports -> rd_data=0x00 and rd_valid=1 one cycle after each rd_en; rd_valid=0 when rd_en is low.
- Write 0xA5 to addr 3; next cycle read addr 3 on port 0 and addr 3 on port 1 -> both 0xA5 after 1 cycle; rd_en low on the following cycle -> rd_data holds 0xA5.
- Same-cycle write 0x3C to addr 5 with read of addr 5 on port 1 -> rd_data[1]=0x3C (bypass).
- Fill entries with 0x11..0x88; pulse clr_req.
  - clr_busy high for 9 cycles (8 CLEAR + 1 DONE); clr_done pulses once.
  - A write of 0xFF during busy is dropped.
  - A read of addr 7 at clear cycle 2 returns 0x88.
  - All entries read 0x00 afterwards.
- Assert rst_n low mid-clear at index 4 -> outputs are reset asynchronously (before the next edge); FSM returns to IDLE; all entries read 0.
- With REG_FILE_MP_PARITY_EN: write 0x01 to addr 2 with inj_par_err=1, then read addr 2 -> rd_data=0x01, rd_err=1. Write 0x01 again without injection -> rd_err=0.

Source files
------------

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
//
// Parametrised multi-read-port architectural register file.
//   - DEPTH = 2**ADDR_W entries of DATA_W bits, NUM_RD registered read ports,
//     one write port.
//   - Write-first bypass: a read that hits the entry being written in the same
//     cycle returns the write data (user write or clear-sequencer zero).
//   - Hardware bulk-clear sequencer (IDLE -> CLEAR -> DONE) zeroes one entry
//     per cycle; user writes are refused while it runs.
//   - ZERO_R0 = 1 hard-wires entry 0 to read as zero and discards writes to it.
//
// Optional feature (compile-time macro REG_FILE_MP_PARITY_EN):
//   each entry carries one even-parity bit; adds ports inj_par_err / rd_err.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   rd_en        in   [NUM_RD]          per-port read enable
//   rd_addr      in   [NUM_RD*ADDR_W]   port i at [i*ADDR_W +: ADDR_W]
//   rd_data      out  [NUM_RD*DATA_W]   registered, port i at [i*DATA_W +: DATA_W]
//   rd_valid     out  [NUM_RD]          one-cycle flag after an accepted read
//   wr_en        in   write request
//   wr_addr      in   [ADDR_W] write address
//   wr_data      in   [DATA_W] write data
//   wr_ready     out  writes accepted (low while the clear sequencer runs)
//   clr_req      in   request bulk clear
//   clr_busy     out  high in CLEAR and DONE
//   clr_done     out  one-cycle pulse in DONE
//   inj_par_err  in   (parity build) invert stored parity of an accepted write
//   rd_err       out  [NUM_RD] (parity build) parity mismatch, with rd_valid
// -----------------------------------------------------------------------------
module reg_file_mp #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 3,
   parameter int NUM_RD  = 2,
   parameter bit ZERO_R0 = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_RD-1:0]          rd_en,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_valid,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       wr_ready,
   input  logic                       clr_req,
   output logic                       clr_busy,
   output logic                       clr_done
`ifdef REG_FILE_MP_PARITY_EN
   ,
   input  logic                       inj_par_err,
   output logic [NUM_RD-1:0]          rd_err
`endif
);

   localparam int DEPTH = 2**ADDR_W;

`ifdef REG_FILE_MP_PARITY_EN
   // Parity bit sits in the MSB of each stored entry.
   localparam int ENTRY_W = DATA_W + 1;
`else
   localparam int ENTRY_W = DATA_W;
`endif

   // Last index of a clear pass; the counter stops here instead of wrapping.
   localparam logic [ADDR_W-1:0] IDX_LAST = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Storage and sequencer state
   // ---------------------------------------------------------------------------
   logic [ENTRY_W-1:0] mem_q [DEPTH];

   state_t             state_q;
   state_t             state_d;
   logic [ADDR_W-1:0]  idx_q;
   logic [ADDR_W-1:0]  idx_d;

   // Single merged array write port, shared by user writes and the clearer.
   logic               wr_acc;
   logic [ENTRY_W-1:0] wr_entry;
   logic               arr_we;
   logic [ADDR_W-1:0]  arr_waddr;
   logic [ENTRY_W-1:0] arr_wentry;

   // ---------------------------------------------------------------------------
   // Handshake outputs, decoded straight from the state register
   // ---------------------------------------------------------------------------
   assign clr_busy = (state_q != IDLE);
   assign clr_done = (state_q == DONE);
   assign wr_ready = !clr_busy;
   assign wr_acc   = wr_en && wr_ready;

`ifdef REG_FILE_MP_PARITY_EN
   // Even parity over the data; injection flips the stored bit for testing
   // the read-side checker.
   assign wr_entry = {(^wr_data) ^ inj_par_err, wr_data};
`else
   assign wr_entry = wr_data;
`endif

   // ---------------------------------------------------------------------------
   // Clear sequencer: next state
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven in an always_comb gets a default at the top, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               idx_d   = '0;
            end
         end
         CLEAR: begin
            if (idx_q == IDX_LAST) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            // clr_req is not sampled here; a held request restarts from IDLE.
            state_d = IDLE;
            idx_d   = '0;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Array write port mux. The clearer and user writes never collide because
   // wr_ready is low for the whole time the clearer owns the port.
   // ---------------------------------------------------------------------------
   always_comb begin
      arr_we     = 1'b0;
      arr_waddr  = wr_addr;
      arr_wentry = '0;
      if (state_q == CLEAR) begin
         arr_we     = 1'b1;
         arr_waddr  = idx_q;
         arr_wentry = '0;
      end else if (wr_acc && !(ZERO_R0 && (wr_addr == '0))) begin
         // Writes to a hard-zero entry 0 are accepted but never reach the array,
         // which also keeps them out of the bypass path.
         arr_we     = 1'b1;
         arr_waddr  = wr_addr;
         arr_wentry = wr_entry;
      end
   end

   // NOTE: the array is flop-based and must read all-zero straight out of
   // reset, so it is reset entry by entry; a RAM macro could not be used here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (arr_we) begin
         mem_q[arr_waddr] <= arr_wentry;
      end
   end

   // ---------------------------------------------------------------------------
   // Read ports: one registered output stage per port, write-first bypass
   // ---------------------------------------------------------------------------
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0]  addr;
      logic               zero_hit;
      logic               byp_hit;
      logic [ENTRY_W-1:0] entry;
      logic [DATA_W-1:0]  data_q;
      logic               valid_q;

      assign addr     = rd_addr[p*ADDR_W +: ADDR_W];
      assign zero_hit = ZERO_R0 && (addr == '0);
      assign byp_hit  = arr_we && (arr_waddr == addr);

      always_comb begin
         entry = mem_q[addr];
         if (zero_hit) begin
            entry = '0;
         end else if (byp_hit) begin
            entry = arr_wentry;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= rd_en[p];
            // Data holds its last value when the port is idle.
            if (rd_en[p]) begin
               data_q <= entry[DATA_W-1:0];
            end
         end
      end

      assign rd_data[p*DATA_W +: DATA_W] = data_q;
      assign rd_valid[p]                 = valid_q;

`ifdef REG_FILE_MP_PARITY_EN
      logic err_d;
      logic err_q;

      // Bypassed and hard-zero reads never come from storage, so they cannot
      // carry a stored-parity error.
      assign err_d = !zero_hit && !byp_hit &&
                     (entry[DATA_W] != (^entry[DATA_W-1:0]));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            err_q <= 1'b0;
         end else begin
            err_q <= rd_en[p] && err_d;
         end
      end

      assign rd_err[p] = err_q;
`endif
   end

endmodule
